// File: rtl/climb_pkg.sv
// rtl/climb_pkg.sv - shared types and widths for the climbing camera controller
package climb_pkg;

    typedef enum logic [1:0] {
        FALL   = 2'd0,
        GRAB_R = 2'd1,
        GRAB_L = 2'd2
    } cam_state_t;

    localparam int SCREEN_W  = 1024;
    localparam int SCREEN_H  = 768;

    localparam int SCREENY_W = 13;
    localparam int SCREENX_W = 12;
    localparam int CALC_W    = 14;
    localparam int VEL_W     = 6;

    // Tracked x gets one spare bit so a hand can run past the visible width.
    localparam int HAND_Y_W  = $clog2(SCREEN_H);
    localparam int HAND_X_W  = $clog2(SCREEN_W) + 1;

endpackage

// File: rtl/scroll_axis.sv
// rtl/scroll_axis.sv - one scroll axis: offset, hand anchor, delta and saturating clamp
module scroll_axis
    import climb_pkg::*;
#(
    parameter int POS_W     = SCREENY_W,
    parameter int HAND_W    = HAND_Y_W,
    parameter int MIN_POS   = -4000,
    parameter int MAX_POS   = 0,
    parameter int RESET_POS = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    latch,
    input  logic                    hold,
    input  logic                    step,
    input  logic [HAND_W-1:0]       hand,
    input  logic [VEL_W-1:0]        step_val,
    output logic signed [POS_W-1:0] pos
);

    localparam logic signed [CALC_W-1:0] LO = CALC_W'(MIN_POS);
    localparam logic signed [CALC_W-1:0] HI = CALC_W'(MAX_POS);

    logic [HAND_W-1:0]        anchor;
    logic signed [HAND_W:0]   delta;
    logic signed [CALC_W-1:0] pos_ext;
    logic signed [CALC_W-1:0] sum;
    logic signed [CALC_W-1:0] clamped;

    // Hand moving down (positive delta) scrolls the view up, hence the subtract.
    always_comb begin
        delta   = {1'b0, hand} - {1'b0, anchor};
        pos_ext = {{(CALC_W-POS_W){pos[POS_W-1]}}, pos};
        sum     = pos_ext;
        if (hold) begin
            sum = pos_ext - {{(CALC_W-HAND_W-1){delta[HAND_W]}}, delta};
        end else if (step) begin
            sum = pos_ext + {{(CALC_W-VEL_W){1'b0}}, step_val};
        end
        if (sum < LO) begin
            clamped = LO;
        end else if (sum > HI) begin
            clamped = HI;
        end else begin
            clamped = sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos    <= POS_W'(RESET_POS);
            anchor <= '0;
        end else begin
            if (latch || hold) begin
                anchor <= hand;
            end
            if (hold || step) begin
                pos <= clamped[POS_W-1:0];
            end
        end
    end

endmodule

// File: rtl/climb_camera.sv
// rtl/climb_camera.sv - per-frame camera/scroll controller; define CLIMB_SCROLL_X_EN for x tracking
module climb_camera
    import climb_pkg::*;
#(
    parameter int FLOOR_Y  = 0,
    parameter int TOP_Y    = -4000,
    parameter int GRAVITY  = 1,
    parameter int MAX_FALL = 24,
    parameter int X_MIN    = -1024,
    parameter int X_MAX    = 1023
) (
    input  logic                        clock_65mhz,
    input  logic                        reset_n,
    input  logic                        vsync,
    input  logic [HAND_X_W-1:0]         userhand1x,
    input  logic [HAND_Y_W-1:0]         userhand1y,
    input  logic [HAND_X_W-1:0]         userhand2x,
    input  logic [HAND_Y_W-1:0]         userhand2y,
    input  logic                        usergrab1,
    input  logic                        usergrab2,
    output logic signed [SCREENY_W-1:0] screeny,
    output logic signed [SCREENX_W-1:0] screenx,
    output logic                        frame_update,
    output logic [1:0]                  cam_state
);

    localparam logic signed [CALC_W-1:0] FLOOR_C = CALC_W'(FLOOR_Y);

    cam_state_t               state, state_next;
    logic [VEL_W-1:0]         vel, vel_inc;
    logic [VEL_W:0]           vel_sum;
    logic signed [CALC_W-1:0] y_fall;
    logic                     floor_hit;
    logic                     vsync_s, vsync_q, tick;
    logic                     ax_latch, ax_hold, ax_step;
    logic [HAND_Y_W-1:0]      hand_y;

    // Both stages reset low so vsync held low across reset release gives no tick.
    assign tick      = vsync_q & ~vsync_s;
    assign cam_state = state;

    always_comb begin
        state_next = state;
        unique case (state)
            FALL:    if (usergrab1) state_next = GRAB_R;
                     else if (usergrab2) state_next = GRAB_L;
            GRAB_R:  if (!usergrab1) state_next = usergrab2 ? GRAB_L : FALL;
            GRAB_L:  if (!usergrab2) state_next = usergrab1 ? GRAB_R : FALL;
            default: state_next = FALL;
        endcase
    end

    always_comb begin
        ax_latch = 1'b0;
        ax_hold  = 1'b0;
        ax_step  = 1'b0;
        if (tick) begin
            if (state_next == FALL) begin
                ax_step = 1'b1;
            end else if (state_next == state) begin
                ax_hold = 1'b1;
            end else begin
                ax_latch = 1'b1;
            end
        end
        hand_y = (state_next == GRAB_L) ? userhand2y : userhand1y;
    end

    always_comb begin
        vel_sum = {1'b0, vel} + (VEL_W+1)'(GRAVITY);
        if (vel_sum > (VEL_W+1)'(MAX_FALL)) begin
            vel_inc = VEL_W'(MAX_FALL);
        end else begin
            vel_inc = vel_sum[VEL_W-1:0];
        end
        y_fall    = {{(CALC_W-SCREENY_W){screeny[SCREENY_W-1]}}, screeny}
                  + {{(CALC_W-VEL_W){1'b0}}, vel_inc};
        floor_hit = (y_fall >= FLOOR_C);
    end

    always_ff @(posedge clock_65mhz or negedge reset_n) begin
        if (!reset_n) begin
            state <= FALL;
        end else if (tick) begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock_65mhz or negedge reset_n) begin
        if (!reset_n) begin
            vsync_s      <= 1'b0;
            vsync_q      <= 1'b0;
            frame_update <= 1'b0;
            vel          <= '0;
        end else begin
            vsync_s      <= vsync;
            vsync_q      <= vsync_s;
            frame_update <= tick;
            if (tick) begin
                vel <= (ax_step && !floor_hit) ? vel_inc : '0;
            end
        end
    end

    scroll_axis #(
        .POS_W     (SCREENY_W),
        .HAND_W    (HAND_Y_W),
        .MIN_POS   (TOP_Y),
        .MAX_POS   (FLOOR_Y),
        .RESET_POS (FLOOR_Y)
    ) u_axis_y (
        .clk      (clock_65mhz),
        .rst_n    (reset_n),
        .latch    (ax_latch),
        .hold     (ax_hold),
        .step     (ax_step),
        .hand     (hand_y),
        .step_val (vel_inc),
        .pos      (screeny)
    );

`ifdef CLIMB_SCROLL_X_EN
    logic [HAND_X_W-1:0] hand_x;

    assign hand_x = (state_next == GRAB_L) ? userhand2x : userhand1x;

    scroll_axis #(
        .POS_W     (SCREENX_W),
        .HAND_W    (HAND_X_W),
        .MIN_POS   (X_MIN),
        .MAX_POS   (X_MAX),
        .RESET_POS (0)
    ) u_axis_x (
        .clk      (clock_65mhz),
        .rst_n    (reset_n),
        .latch    (ax_latch),
        .hold     (ax_hold),
        .step     (1'b0),
        .hand     (hand_x),
        .step_val ('0),
        .pos      (screenx)
    );
`else
    logic unused_x;

    assign screenx  = '0;
    assign unused_x = ^{userhand1x, userhand2x, X_MIN[0], X_MAX[0]};
`endif

endmodule

// File: tb/tb_climb_camera.sv
// tb/tb_climb_camera.sv - directed self-checking bench for climb_camera
module tb_climb_camera;

    logic               clk;
    logic               reset_n;
    logic               vsync;
    logic [10:0]        userhand1x, userhand2x;
    logic [9:0]         userhand1y, userhand2y;
    logic               usergrab1, usergrab2;
    logic signed [12:0] screeny;
    logic signed [11:0] screenx;
    logic               frame_update;
    logic [1:0]         cam_state;

    int   total = 0;
    int   bad   = 0;
    logic fu_early, fu_on, fu_after;

    climb_camera dut (
        .clock_65mhz  (clk),
        .reset_n      (reset_n),
        .vsync        (vsync),
        .userhand1x   (userhand1x),
        .userhand1y   (userhand1y),
        .userhand2x   (userhand2x),
        .userhand2y   (userhand2y),
        .usergrab1    (usergrab1),
        .usergrab2    (usergrab2),
        .screeny      (screeny),
        .screenx      (screenx),
        .frame_update (frame_update),
        .cam_state    (cam_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One frame: vsync falls at a negedge, outputs are sampled on following negedges.
    task automatic frame();
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        fu_early = frame_update;
        @(negedge clk);
        fu_on = frame_update;
        vsync = 1'b1;
        @(negedge clk);
        fu_after = frame_update;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        vsync = 1'b1;
        usergrab1 = 1'b0; usergrab2 = 1'b0;
        userhand1x = '0; userhand2x = '0; userhand1y = '0; userhand2y = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        total++; if (screeny !== 0) begin bad++; $display("FAIL reset_screeny got=%0d want=0", screeny); end
        total++; if (screenx !== 0) begin bad++; $display("FAIL reset_screenx got=%0d want=0", screenx); end
        total++; if (frame_update !== 1'b0) begin bad++; $display("FAIL reset_frame_update got=%b want=0", frame_update); end
        total++; if (cam_state !== 2'd0) begin bad++; $display("FAIL reset_cam_state got=%0d want=0", cam_state); end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            frame();
            total++; if (fu_early !== 1'b0 || fu_on !== 1'b1 || fu_after !== 1'b0) begin
                bad++; $display("FAIL idle_pulse[%0d] got=%b%b%b want=010", i, fu_early, fu_on, fu_after);
            end
            total++; if (screeny !== 0 || dut.vel !== 0) begin
                bad++; $display("FAIL idle_floor[%0d] got y=%0d vel=%0d want y=0 vel=0", i, screeny, dut.vel);
            end
        end
    endtask

    task automatic test_between_ticks();
        usergrab1 = 1'b1;
        userhand1y = 10'd123;
        repeat (6) @(negedge clk);
        total++; if (cam_state !== 2'd0 || screeny !== 0 || frame_update !== 1'b0) begin
            bad++; $display("FAIL no_tick_effect got state=%0d y=%0d fu=%b want 0/0/0", cam_state, screeny, frame_update);
        end
        usergrab1 = 1'b0;
    endtask

    task automatic test_hold();
        int ys [3]    = '{400, 450, 470};
        int exp_y [3] = '{0, -50, -70};
        usergrab1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            userhand1y = 10'(ys[i]);
            frame();
            total++; if (screeny !== exp_y[i] || cam_state !== 2'd1) begin
                bad++; $display("FAIL hold[%0d] got y=%0d state=%0d want y=%0d state=1", i, screeny, cam_state, exp_y[i]);
            end
        end
        total++; if (screenx !== 0) begin bad++; $display("FAIL hold_screenx got=%0d want=0", screenx); end
    endtask

    task automatic test_fall();
        int exp_y [12] = '{-69, -67, -64, -60, -55, -49, -42, -34, -25, -15, -4, 0};
        usergrab1 = 1'b0;
        usergrab2 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            frame();
            total++; if (screeny !== exp_y[i] || cam_state !== 2'd0) begin
                bad++; $display("FAIL fall[%0d] got y=%0d state=%0d want y=%0d state=0", i, screeny, cam_state, exp_y[i]);
            end
        end
        total++; if (dut.vel !== 0) begin bad++; $display("FAIL fall_floor_vel got=%0d want=0", dut.vel); end
    endtask

    task automatic test_floor_clamp();
        usergrab1 = 1'b1;
        userhand1y = 10'd0;
        frame();
        userhand1y = 10'd334;
        frame();
        total++; if (screeny !== -334) begin bad++; $display("FAIL lift got=%0d want=-334", screeny); end
        usergrab1 = 1'b0;
        repeat (24) frame();
        total++; if (screeny !== -34 || dut.vel !== 24) begin
            bad++; $display("FAIL vel_ramp got y=%0d vel=%0d want y=-34 vel=24", screeny, dut.vel);
        end
        frame();
        total++; if (screeny !== -10 || dut.vel !== 24) begin
            bad++; $display("FAIL vel_sat got y=%0d vel=%0d want y=-10 vel=24", screeny, dut.vel);
        end
        frame();
        total++; if (screeny !== 0 || dut.vel !== 0) begin
            bad++; $display("FAIL floor_clamp got y=%0d vel=%0d want y=0 vel=0", screeny, dut.vel);
        end
    endtask

    task automatic test_handover();
        usergrab1 = 1'b1; usergrab2 = 1'b1;
        userhand1y = 10'd100; userhand2y = 10'd200;
        frame();
        total++; if (cam_state !== 2'd1 || screeny !== 0) begin
            bad++; $display("FAIL both_grab got state=%0d y=%0d want state=1 y=0", cam_state, screeny);
        end
        userhand1y = 10'd150;
        frame();
        total++; if (cam_state !== 2'd1 || screeny !== -50) begin
            bad++; $display("FAIL both_hold got state=%0d y=%0d want state=1 y=-50", cam_state, screeny);
        end
        usergrab1 = 1'b0;
        userhand2y = 10'd260;
        frame();
        total++; if (cam_state !== 2'd2 || screeny !== -50) begin
            bad++; $display("FAIL handover got state=%0d y=%0d want state=2 y=-50", cam_state, screeny);
        end
        userhand2y = 10'd300;
        frame();
        total++; if (cam_state !== 2'd2 || screeny !== -90) begin
            bad++; $display("FAIL left_hold got state=%0d y=%0d want state=2 y=-90", cam_state, screeny);
        end
    endtask

    task automatic test_saturate();
        bit g1 [12]    = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0};
        bit g2 [12]    = '{1, 0, 0, 1, 1, 0, 0, 1, 1, 1, 1, 1};
        int y1 [12]    = '{0, 0, 1000, 1000, 1000, 0, 1000, 1000, 1000, 1000, 1000, 1000};
        int y2 [12]    = '{1000, 1000, 1000, 0, 1000, 1000, 1000, 0, 110, 610, 1010, 10};
        int exp_s [12] = '{2, 1, 1, 2, 2, 1, 1, 2, 2, 2, 2, 2};
        int exp_y [12] = '{-790, -790, -1790, -1790, -2790, -2790, -3790, -3790, -3900, -4000, -4000, -3000};
        for (int i = 0; i < 12; i++) begin
            usergrab1 = g1[i]; usergrab2 = g2[i];
            userhand1y = 10'(y1[i]); userhand2y = 10'(y2[i]);
            frame();
            total++; if (cam_state !== 2'(exp_s[i]) || screeny !== exp_y[i]) begin
                bad++; $display("FAIL saturate[%0d] got state=%0d y=%0d want state=%0d y=%0d",
                                i, cam_state, screeny, exp_s[i], exp_y[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic seen;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        usergrab1 = 1'b0; usergrab2 = 1'b1;
        userhand2y = 10'd0;
        repeat (3) @(negedge clk);
        frame();
        userhand2y = 10'd300;
        frame();
        total++; if (cam_state !== 2'd2 || screeny !== -300) begin
            bad++; $display("FAIL pre_reset got state=%0d y=%0d want state=2 y=-300", cam_state, screeny);
        end
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        total++; if (screeny !== 0 || screenx !== 0 || cam_state !== 2'd0 || frame_update !== 1'b0) begin
            bad++; $display("FAIL async_reset got y=%0d x=%0d state=%0d fu=%b want 0/0/0/0",
                            screeny, screenx, cam_state, frame_update);
        end
        vsync = 1'b0;
        usergrab2 = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | frame_update;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL low_vsync_release got pulse=%b want=0", seen); end
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        frame();
        total++; if (fu_on !== 1'b1 || screeny !== 0 || cam_state !== 2'd0 || dut.vel !== 0) begin
            bad++; $display("FAIL first_tick got fu=%b y=%0d state=%0d vel=%0d want 1/0/0/0",
                            fu_on, screeny, cam_state, dut.vel);
        end
    endtask

    task automatic test_scroll_x();
        int exp_x;
`ifdef CLIMB_SCROLL_X_EN
        exp_x = 50;
`else
        exp_x = 0;
`endif
        usergrab1 = 1'b1;
        userhand1y = 10'd0;
        userhand1x = 11'd600;
        frame();
        total++; if (screenx !== 0 || cam_state !== 2'd1) begin
            bad++; $display("FAIL x_latch got x=%0d state=%0d want x=0 state=1", screenx, cam_state);
        end
        userhand1x = 11'd550;
        frame();
        total++; if (screenx !== exp_x || screeny !== 0) begin
            bad++; $display("FAIL x_hold got x=%0d y=%0d want x=%0d y=0", screenx, screeny, exp_x);
        end
        usergrab1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_between_ticks();
        test_hold();
        test_fall();
        test_floor_clamp();
        test_handover();
        test_saturate();
        test_async_reset();
        test_scroll_x();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
